pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces fixed-width, enable-only stage latches between CPU pipeline stages. Back-pressure from a stalled downstream stage is absorbed without a combinational ready path. Flush kills in-flight entries on branch, jump or jr redirect.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage_skid_flopenrn.sv | 19 +
 rtl/pipe_stage_skid.sv | 92 +++++++++
 tb/tb_pipe_stage_skid.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types.
// Skid stage state encoding lives here.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_flopenrn.sv
// Enable register with async active-low reset.
// Used for the main and skid entries of the stage.
module flopenrn #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with one-entry skid buffer.
// Outputs decode from state only; flush empties the stage.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_t state, state_nx;
  logic in_f, out_f;
  logic main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign occupancy = state;
  assign in_f  = in_valid & in_ready;
  assign out_f = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_d   = in_data;
    unique case (state)
      ST_EMPTY: begin
        if (in_f) begin
          state_nx = ST_ONE;
          main_en  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_f && out_f) begin
          main_en = 1'b1;
        end else if (in_f) begin
          state_nx = ST_FULL;
          skid_en  = 1'b1;
        end else if (out_f) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        main_d = skid_q;
        if (out_f) begin
          state_nx = ST_ONE;
          main_en  = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    // A killed entry must never reach out_data.
    if (flush) begin
      state_nx = ST_EMPTY;
      main_en  = 1'b0;
      skid_en  = 1'b0;
    end
  end

  flopenrn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  flopenrn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid.
// Expected values are hand-computed per step.
module tb_pipe_stage_skid;

  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0] occupancy;

  int n_chk = 0;
  int n_pass = 0;

  pipe_stage_skid #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic v, input logic r,
                        input logic [1:0] o);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(r));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(o));
  endtask

  initial begin
    // reset held with input offered
    in_valid = 1'b1;
    in_data  = 32'h1;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st("reset", 1'b0, 1'b1, 2'd0);
      chk("reset.data", out_data, RV);
    end
    in_valid = 1'b0;
    reset = 1'b1;

    // streaming
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h10;
    step();
    chk_st("s10", 1'b1, 1'b1, 2'd1);
    chk("s10.data", out_data, 32'h10);
    in_data = 32'h11;
    step();
    chk_st("s11", 1'b1, 1'b1, 2'd1);
    chk("s11.data", out_data, 32'h11);
    in_data = 32'h12;
    step();
    chk_st("s12", 1'b1, 1'b1, 2'd1);
    chk("s12.data", out_data, 32'h12);
    in_valid = 1'b0;
    step();
    chk_st("sdrain", 1'b0, 1'b1, 2'd0);
    chk("sdrain.data", out_data, 32'h12);

    // stall into skid
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA0;
    step();
    chk_st("a0", 1'b1, 1'b1, 2'd1);
    chk("a0.data", out_data, 32'hA0);
    in_data = 32'hA1;
    step();
    chk_st("a1", 1'b1, 1'b0, 2'd2);
    chk("a1.data", out_data, 32'hA0);
    in_data = 32'hA2;
    step();
    chk_st("a2hold", 1'b1, 1'b0, 2'd2);
    chk("a2hold.data", out_data, 32'hA0);
    out_ready = 1'b1;
    step();
    chk_st("outa1", 1'b1, 1'b1, 2'd1);
    chk("outa1.data", out_data, 32'hA1);
    step();
    chk_st("outa2", 1'b1, 1'b1, 2'd1);
    chk("outa2.data", out_data, 32'hA2);
    in_valid = 1'b0;
    step();
    chk_st("adrain", 1'b0, 1'b1, 2'd0);

    // flush while FULL with input offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hC0;
    step();
    in_data = 32'hC1;
    step();
    chk_st("cfull", 1'b1, 1'b0, 2'd2);
    flush = 1'b1;
    in_data = 32'hC2;
    step();
    chk_st("cflush", 1'b0, 1'b1, 2'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk_st("cafter", 1'b0, 1'b1, 2'd0);
    chk("cafter.data", out_data, 32'hC0);

    // flush in ONE with a simultaneous input transfer
    in_valid = 1'b1;
    in_data = 32'hB4;
    step();
    chk_st("b4", 1'b1, 1'b1, 2'd1);
    in_data = 32'hB5;
    flush = 1'b1;
    step();
    chk_st("bflush", 1'b0, 1'b1, 2'd0);
    chk("bflush.data", out_data, 32'hB4);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk_st("bafter", 1'b0, 1'b1, 2'd0);
    chk("bafter.data", out_data, 32'hB4);

    // async reset mid-stall
    in_valid = 1'b1;
    in_data = 32'hD0;
    step();
    in_data = 32'hD1;
    step();
    chk_st("dfull", 1'b1, 1'b0, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_st("arst", 1'b0, 1'b1, 2'd0);
    chk("arst.data", out_data, RV);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h7;
    step();
    chk_st("p7", 1'b1, 1'b1, 2'd1);
    chk("p7.data", out_data, 32'h7);
    in_valid = 1'b0;
    step();
    chk_st("p7drain", 1'b0, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
